tspi_tx_arb: RTL and testbench

- Round-robin scheduler that shares one SPI transmit word path (txd controller plus shifter) between NUM_REQ frame sources.
- Grants one requester at a time and drives txd_en for the length of a frame.
- Routes the downstream per-word data request to the granted source, and muxes that source's valid/data back.
- Sits between the per-channel TX FIFOs and the txd controller; enforces a per-frame word cap and an inter-frame gap.

---
 rtl/tspi_tx_arb.sv | 167 ++++++++++++++++
 tb/tb_tspi_tx_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tspi_tx_arb.sv
// Round-robin arbiter sharing one SPI transmit word path between NUM_REQ frame sources.
// Optional watchdog abort is compiled in with `define TSPI_ARB_WDOG_EN.
module tspi_tx_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DW        = 8,
  parameter int MAX_WORDS = 16,
  parameter int GAP_CYC   = 2,
  parameter int WDOG_CYC  = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_dreq,
  output logic [NUM_REQ-1:0]    req_done,
  output logic                  txd_en,
  input  logic                  tx_dreq,
  output logic                  tx_valid,
  output logic [DW-1:0]         tx_data,
  input  logic                  txd_cmpt,
  output logic                  busy,
  output logic                  arb_err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [7:0]      cnt;
  logic [3:0]      gap_cnt;
  logic [PW-1:0]   sel;
  logic            sel_ok;
  logic            in_run;
  logic            consume;
`ifdef TSPI_ARB_WDOG_EN
  logic [15:0]     wdog_cnt;
`endif

  assign in_run  = (state == S_RUN);
  assign busy    = (state != S_IDLE);
  assign consume = in_run & tx_dreq & tx_valid;

  // Round-robin pick: first requester strictly after the last-served pointer.
  always_comb begin
    sel    = '0;
    sel_ok = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!sel_ok && req[(int'(ptr) + k) % NUM_REQ]) begin
        sel    = PW'((int'(ptr) + k) % NUM_REQ);
        sel_ok = 1'b1;
      end else begin
        sel    = sel;
        sel_ok = sel_ok;
      end
    end
  end

  // Word path toward the txd controller; valid is capped at MAX_WORDS per grant.
  always_comb begin
    tx_data  = '0;
    req_dreq = '0;
    tx_valid = 1'b0;
    if (in_run) begin
      req_dreq = gnt & {NUM_REQ{tx_dreq}};
      tx_valid = (|(req_valid & gnt)) & (cnt < 8'(MAX_WORDS));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          tx_data = tx_data | req_data[i*DW +: DW];
        end else begin
          tx_data = tx_data;
        end
      end
    end else begin
      tx_data  = '0;
    end
  end

  // Arbitration FSM with registered grant, frame enable and status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      gnt      <= '0;
      txd_en   <= 1'b0;
      req_done <= '0;
      arb_err  <= 1'b0;
      cnt      <= 8'd0;
      gap_cnt  <= 4'd0;
      ptr      <= PW'(NUM_REQ - 1);
`ifdef TSPI_ARB_WDOG_EN
      wdog_cnt <= 16'd0;
`endif
    end else begin
      req_done <= '0;
      arb_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel_ok) begin
            gnt    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
            txd_en <= 1'b1;
            ptr    <= sel;
            cnt    <= 8'd0;
            state  <= S_RUN;
`ifdef TSPI_ARB_WDOG_EN
            wdog_cnt <= 16'd0;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (consume) begin
            cnt <= cnt + 8'd1;
          end else begin
            cnt <= cnt;
          end
`ifdef TSPI_ARB_WDOG_EN
          wdog_cnt <= wdog_cnt + 16'd1;
`endif
          if (txd_cmpt) begin
            txd_en        <= 1'b0;
            gnt           <= '0;
            req_done[ptr] <= 1'b1;
            state         <= S_DONE;
`ifdef TSPI_ARB_WDOG_EN
          end else if (wdog_cnt == 16'(WDOG_CYC - 1)) begin
            // Abort a hung frame; pointer already moved so others are served next.
            txd_en  <= 1'b0;
            gnt     <= '0;
            arb_err <= 1'b1;
            state   <= S_DONE;
`endif
          end else begin
            state <= S_RUN;
          end
        end
        S_DONE: begin
          gap_cnt <= 4'd0;
          if (GAP_CYC > 0) begin
            state <= S_GAP;
          end else begin
            state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt == 4'(GAP_CYC - 1)) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tspi_tx_arb.sv
// Self-checking bench for tspi_tx_arb: directed steps plus randomized frames
// checked against a queue-based round-robin model.
module tb_tspi_tx_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_v;
  logic [3:0]  gnt;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_dreq;
  logic [3:0]  req_done;
  logic        txd_en;
  logic        tx_dreq;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        txd_cmpt;
  logic        busy;
  logic        arb_err;

  int total = 0;
  int bad   = 0;
  int ptr;
  logic [7:0] mem [4][256];
  int head [4];
  int tail [4];

  always #5 clk = ~clk;

  tspi_tx_arb dut (
    .clk(clk), .rst(rst), .req(req_v), .gnt(gnt),
    .req_valid(req_valid), .req_data(req_data), .req_dreq(req_dreq),
    .req_done(req_done), .txd_en(txd_en), .tx_dreq(tx_dreq),
    .tx_valid(tx_valid), .tx_data(tx_data), .txd_cmpt(txd_cmpt),
    .busy(busy), .arb_err(arb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int qlen(input int s);
    return tail[s] - head[s];
  endfunction

  task automatic push(input int s, input logic [7:0] w);
    mem[s][tail[s] % 256] = w;
    tail[s]++;
  endtask

  function automatic int rr(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  task automatic drive_src();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (qlen(i) > 0);
      req_data[i*8 +: 8] = req_valid[i] ? mem[i][head[i] % 256] : 8'h00;
    end
  endtask

  task automatic wait_grant();
    int w;
    w = 0;
    do begin
      @(negedge clk); drive_src(); #1; w++;
    end while (txd_en !== 1'b1 && w < 20);
    chk("grant_wait", 32'(txd_en), 32'd1);
  endtask

  // One complete frame: the bench acts as txd controller, ending the frame
  // with txd_cmpt on the first request that finds no valid word.
  task automatic do_frame(input bit wiggle);
    int e, n, exp_n;
    e = rr(req_v, ptr);
    exp_n = (qlen(e) > 16) ? 16 : qlen(e);
    wait_grant();
    chk("gnt", 32'(gnt), 32'(1 << e));
    chk("busy_run", 32'(busy), 32'd1);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tx_dreq = 1'b1; #1;
      chk("req_dreq", 32'(req_dreq), 32'(1 << e));
      if (tx_valid !== 1'b1) break;
      chk("tx_data", 32'(tx_data), 32'(mem[e][head[e] % 256]));
      head[e]++; n++;
      if (wiggle) req_v = 4'($urandom);
      @(negedge clk); drive_src(); #1;
    end
    chk("words", n, exp_n);
    tx_dreq = 1'b0; txd_cmpt = 1'b1;
    @(negedge clk); #1;
    chk("done_txd_en", 32'(txd_en), 32'd0);
    chk("done_gnt", 32'(gnt), 32'd0);
    chk("done_pulse", 32'(req_done), 32'(1 << e));
    chk("done_err", 32'(arb_err), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    txd_cmpt = 1'b0;
    ptr = e;
    @(negedge clk); #1;
    chk("pulse_once", 32'(req_done), 32'd0);
    chk("gap_txd_en", 32'(txd_en), 32'd0);
    chk("gap_dreq", 32'(req_dreq), 32'd0);
  endtask

  initial begin
    rst = 1'b0; req_v = 4'd0; tx_dreq = 1'b0; txd_cmpt = 1'b0;
    req_valid = 4'd0; req_data = 32'd0;
    for (int i = 0; i < 4; i++) begin head[i] = 0; tail[i] = 0; end
    ptr = 3;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1; tx_dreq = 1'b1; #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_txd_en", 32'(txd_en), 32'd0);
    chk("rst_done", 32'(req_done), 32'd0);
    chk("rst_err", 32'(arb_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(tx_valid), 32'd0);
    chk("idle_dreq", 32'(req_dreq), 32'd0);
    tx_dreq = 1'b0;

    // Single source, three words, then gap back to idle.
    req_v = 4'b0001;
    push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
    do_frame(1'b0);
    req_v = 4'b0000;
    @(negedge clk); #1;
    chk("gap2_busy", 32'(busy), 32'd1);
    @(negedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_gnt", 32'(gnt), 32'd0);

    // Strict round-robin among persistent requesters, one word each.
    req_v = 4'b1011;
    repeat (6) begin
      for (int s = 0; s < 4; s++) begin
        if (req_v[s] && qlen(s) == 0) push(s, 8'($urandom));
      end
      do_frame(1'b0);
    end

    // Zero-length frame.
    req_v = 4'b0010;
    head[1] = tail[1];
    do_frame(1'b0);

    // Word cap on two always-valid sources.
    req_v = 4'b0110;
    head[1] = tail[1]; head[2] = tail[2];
    repeat (20) begin push(1, 8'($urandom)); push(2, 8'($urandom)); end
    do_frame(1'b0);
    do_frame(1'b0);
    head[1] = tail[1]; head[2] = tail[2];

    // Randomized frames, req wiggled mid-frame.
    for (int it = 0; it < 14; it++) begin
      req_v = 4'($urandom_range(1, 15));
      for (int s = 0; s < 4; s++) begin
        if (req_v[s] && qlen(s) == 0) begin
          int len;
          len = $urandom_range(0, 20);
          for (int k = 0; k < len; k++) push(s, 8'($urandom));
        end
      end
      do_frame(1'b1);
    end

    // Reset mid-frame after two of five words.
    req_v = 4'b1000;
    head[3] = tail[3];
    for (int k = 0; k < 5; k++) push(3, 8'(8'h30 + k));
    repeat (4) @(negedge clk);
    wait_grant();
    chk("rstmid_gnt", 32'(gnt), 32'd8);
    repeat (2) begin
      tx_dreq = 1'b1; #1;
      chk("rstmid_valid", 32'(tx_valid), 32'd1);
      chk("rstmid_data", 32'(tx_data), 32'(mem[3][head[3] % 256]));
      head[3]++;
      @(negedge clk); drive_src(); #1;
    end
    tx_dreq = 1'b0; rst = 1'b0; req_v = 4'b0110;
    @(negedge clk); #1;
    chk("rstmid_gnt0", 32'(gnt), 32'd0);
    chk("rstmid_txd_en", 32'(txd_en), 32'd0);
    chk("rstmid_done", 32'(req_done), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    head[3] = tail[3];
    head[1] = tail[1]; head[2] = tail[2];
    push(1, 8'h5A); push(1, 8'h5B);
    ptr = 3;
    do_frame(1'b0);

    req_v = 4'b0000;
    repeat (5) @(negedge clk);
    #1;
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_err", 32'(arb_err), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
